grad_acc_1: RTL and testbench

Gradient accumulate-and-update stage for the GRU hidden layer, directly downstream of the per-timestep gradient product unit. It consumes one Q2.14 gradient term per valid pulse over a sequence of `len` timesteps, sums them in a wide accumulator, then produces the saturated gradient sum and the updated weight `w_out = w_in - (sum >>> lr_shift)`. Its `in_valid`/`in_data` pins connect straight to the product unit's `result_valid`/`result`.

---
 rtl/grad_acc_1.sv | 167 ++++++++++++++++
 tb/tb_grad_acc_1.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/grad_acc_1.sv
// rtl/grad_acc_1.sv - gradient accumulate-and-update stage for the GRU hidden layer
//
// Purpose:
//   Sums i_len signed Q2.14 gradient terms, one per i_in_valid pulse, in a
//   wide accumulator. It then produces the narrowed gradient sum and the
//   updated weight w_out = w_in - (acc >>> lr_shift).
//
// Configuration:
//   GRAD_ACC_SAT_EN - when defined, accumulator adds saturate at the ACCBIT
//                     signed limits and narrowing clamps to the DATABIT signed
//                     range. When undefined, the accumulator wraps and
//                     narrowing truncates to the low DATABIT bits.
//
// Parameters:
//   DATABIT       data width (Q2.14, 1.0 = 0x4000)
//   ACCBIT        accumulator width, must be >= DATABIT+8
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       begin a sequence (sampled only in IDLE)
//   i_len         number of terms to accumulate, latched on start
//   i_w_in        current weight, latched on start
//   i_lr_shift    learning-rate right shift, latched on start
//   i_in_valid    gradient term valid (product unit result_valid)
//   i_in_data     gradient term (product unit result)
//   o_busy        high in ACCUM and UPDATE
//   o_out_valid   one-cycle pulse when o_grad_sum / o_w_out are updated
//   o_grad_sum    narrowed accumulated gradient
//   o_w_out       narrowed updated weight

module grad_acc_1 #(
  parameter int DATABIT = 16,
  parameter int ACCBIT  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [7:0]                i_len,
  input  logic signed [DATABIT-1:0] i_w_in,
  input  logic [3:0]                i_lr_shift,
  input  logic                      i_in_valid,
  input  logic signed [DATABIT-1:0] i_in_data,
  output logic                      o_busy,
  output logic                      o_out_valid,
  output logic signed [DATABIT-1:0] o_grad_sum,
  output logic signed [DATABIT-1:0] o_w_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  logic [1:0]                r_state;
  logic [7:0]                r_len;
  logic [7:0]                r_cnt;
  logic signed [DATABIT-1:0] r_w_in;
  logic [3:0]                r_lr_shift;
  logic signed [ACCBIT-1:0]  r_acc;
  logic                      r_out_valid;
  logic signed [DATABIT-1:0] r_grad_sum;
  logic signed [DATABIT-1:0] r_w_out;

  logic signed [ACCBIT-1:0]  w_term_ext;
  logic signed [ACCBIT-1:0]  w_sum_raw;
  logic signed [ACCBIT-1:0]  w_sum;
  logic signed [ACCBIT-1:0]  w_w_in_ext;
  logic signed [ACCBIT-1:0]  w_scaled;
  logic signed [ACCBIT-1:0]  w_diff;
  logic                      w_last_term;

  // Reduce an ACCBIT value to DATABIT. A value fits when every bit from the
  // DATABIT sign position upward equals the sign; otherwise it clamps to the
  // rail on the side given by its sign.
  function automatic logic signed [DATABIT-1:0] f_narrow(input logic signed [ACCBIT-1:0] v);
`ifdef GRAD_ACC_SAT_EN
    logic fits;
    fits = (v[ACCBIT-1:DATABIT-1] == {(ACCBIT-DATABIT+1){1'b0}}) ||
           (v[ACCBIT-1:DATABIT-1] == {(ACCBIT-DATABIT+1){1'b1}});
    if (fits) begin
      return v[DATABIT-1:0];
    end else if (v[ACCBIT-1]) begin
      return {1'b1, {(DATABIT-1){1'b0}}};
    end else begin
      return {1'b0, {(DATABIT-1){1'b1}}};
    end
`else
    return v[DATABIT-1:0];
`endif
  endfunction

  assign w_term_ext = {{(ACCBIT-DATABIT){i_in_data[DATABIT-1]}}, i_in_data};
  assign w_sum_raw  = r_acc + w_term_ext;

`ifdef GRAD_ACC_SAT_EN
  // Signed overflow: operands share a sign and the result does not.
  logic w_ovf;
  assign w_ovf = (r_acc[ACCBIT-1] == w_term_ext[ACCBIT-1]) &&
                 (w_sum_raw[ACCBIT-1] != r_acc[ACCBIT-1]);
  always_comb begin
    w_sum = w_sum_raw;
    if (w_ovf) begin
      w_sum = r_acc[ACCBIT-1] ? {1'b1, {(ACCBIT-1){1'b0}}}
                              : {1'b0, {(ACCBIT-1){1'b1}}};
    end
  end
`else
  assign w_sum = w_sum_raw;
`endif

  assign w_w_in_ext  = {{(ACCBIT-DATABIT){r_w_in[DATABIT-1]}}, r_w_in};
  assign w_scaled    = r_acc >>> r_lr_shift;
  assign w_diff      = w_w_in_ext - w_scaled;
  assign w_last_term = (r_cnt == (r_len - 8'd1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_w_in      <= '0;
      r_lr_shift  <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_grad_sum  <= '0;
      r_w_out     <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_len      <= i_len;
            r_w_in     <= i_w_in;
            r_lr_shift <= i_lr_shift;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= (i_len != 8'd0) ? ST_ACCUM : ST_UPDATE;
          end
        end
        ST_ACCUM: begin
          if (i_in_valid) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 8'd1;
            if (w_last_term) begin
              r_state <= ST_UPDATE;
            end
          end
        end
        ST_UPDATE: begin
          r_grad_sum  <= f_narrow(r_acc);
          r_w_out     <= f_narrow(w_diff);
          r_out_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_grad_sum  = r_grad_sum;
  assign o_w_out     = r_w_out;

endmodule

// File: tb/tb_grad_acc_1.sv
// tb/tb_grad_acc_1.sv - directed self-checking bench for grad_acc_1

module tb_grad_acc_1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [15:0] w_in;
  logic [3:0]  lr_shift;
  logic        in_valid;
  logic [15:0] in_data;
  logic        busy;
  logic        out_valid;
  logic [15:0] grad_sum;
  logic [15:0] w_out;

  int n_checks;
  int n_errors;

  grad_acc_1 #(.DATABIT(16), .ACCBIT(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_len       (len),
    .i_w_in      (w_in),
    .i_lr_shift  (lr_shift),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_busy      (busy),
    .o_out_valid (out_valid),
    .o_grad_sum  (grad_sum),
    .o_w_out     (w_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [7:0] l, input logic [15:0] w, input logic [3:0] sh);
    start    = 1'b1;
    len      = l;
    w_in     = w;
    lr_shift = sh;
    tick();
    start    = 1'b0;
    len      = 8'hFF;
    w_in     = 16'h5555;
    lr_shift = 4'hF;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Idle gap cycles (busy must stay high), optionally with a stray start
  // pulse carrying a different len, then one accepted term.
  task automatic push(input logic [15:0] d, input int gap, input bit noise);
    for (int g = 0; g < gap; g++) begin
      if (noise && g == 1) begin
        start = 1'b1;
        len   = 8'd1;
      end
      tick();
      start = 1'b0;
      chk("busy_in_gap", {31'd0, busy}, 32'd1);
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 16'h0;
  endtask

  // Called #1 after the edge that accepted the last term (or the start for
  // len=0); leaves the bench inside the out_valid cycle.
  task automatic expect_result(input string tag, input logic [15:0] gs, input logic [15:0] w);
    chk({tag, "_ov_early"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy_update"}, {31'd0, busy}, 32'd1);
    tick();
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_grad_sum"}, {16'd0, grad_sum}, {16'd0, gs});
    chk({tag, "_w_out"}, {16'd0, w_out}, {16'd0, w});
  endtask

  task automatic expect_drop(input string tag, input logic [15:0] gs, input logic [15:0] w);
    tick();
    chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_gs_hold"}, {16'd0, grad_sum}, {16'd0, gs});
    chk({tag, "_w_hold"}, {16'd0, w_out}, {16'd0, w});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = 8'd0;
    w_in     = 16'd0;
    lr_shift = 4'd0;
    in_valid = 1'b0;
    in_data  = 16'd0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_gs", {16'd0, grad_sum}, 32'd0);
    chk("rst_w", {16'd0, w_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back: 4 x 0x1000 = 0x4000; 0x4000 - (0x4000>>>2) = 0x3000.
    start_seq(8'd4, 16'h4000, 4'd2);
    for (int k = 0; k < 4; k++) push(16'h1000, 0, 1'b0);
    expect_result("b2b", 16'h4000, 16'h3000);

    // A start during the out_valid cycle is accepted: len=0 run.
    start_seq(8'd0, 16'h2000, 4'd3);
    expect_result("len0", 16'h0000, 16'h2000);
    expect_drop("len0", 16'h0000, 16'h2000);

    // Gapped terms (5 idle cycles each) give the same result.
    start_seq(8'd4, 16'h4000, 4'd2);
    push(16'h1000, 0, 1'b0);
    for (int k = 0; k < 3; k++) push(16'h1000, 5, 1'b0);
    expect_result("gap", 16'h4000, 16'h3000);
    expect_drop("gap", 16'h4000, 16'h3000);

    // Stray term in IDLE and stray starts mid-ACCUM are ignored.
    push(16'h7000, 0, 1'b0);
    chk("idle_term_busy", {31'd0, busy}, 32'd0);
    start_seq(8'd4, 16'h4000, 4'd2);
    push(16'h1000, 0, 1'b0);
    for (int k = 0; k < 3; k++) push(16'h1000, 3, 1'b1);
    expect_result("noise", 16'h4000, 16'h3000);
    expect_drop("noise", 16'h4000, 16'h3000);

    // 4 x 0x7FFF = 0x1FFFC; -32768 - 131068 = -163836 = 0xFFFD8004.
    start_seq(8'd4, 16'h8000, 4'd0);
    for (int k = 0; k < 4; k++) push(16'h7FFF, 0, 1'b0);
`ifdef GRAD_ACC_SAT_EN
    expect_result("big", 16'h7FFF, 16'h8000);
`else
    expect_result("big", 16'hFFFC, 16'h8004);
`endif

    // Reset mid-sequence clears everything immediately.
    tick();
    start_seq(8'd8, 16'h1234, 4'd1);
    for (int k = 0; k < 3; k++) push(16'h0100, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ov", {31'd0, out_valid}, 32'd0);
    chk("mrst_gs", {16'd0, grad_sum}, 32'd0);
    chk("mrst_w", {16'd0, w_out}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Fresh len=1 run: 0 - 0x0400 = 0xFC00.
    start_seq(8'd1, 16'h0000, 4'd0);
    push(16'h0400, 0, 1'b0);
    expect_result("fresh", 16'h0400, 16'hFC00);
    expect_drop("fresh", 16'h0400, 16'hFC00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
